// File: rtl/dp_ram_stream_reader_pkg.sv
// Shared definitions for the dual-port RAM stream reader and companion RAM writers:
// FSM state encoding and the output FIFO depth.
package dp_ram_stream_reader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } ram_fsm_state_e;

   localparam int unsigned OUT_FIFO_DEPTH = 2;

endpackage

// File: rtl/dp_ram_stream_reader_if.sv
// Valid/ready stream carrying RAM words plus an end-of-burst marker.
interface dp_ram_stream_reader_if #(
   parameter int DATA_BITWIDTH = 512
);
   logic                     m_valid;
   logic [DATA_BITWIDTH-1:0] m_data;
   logic                     m_last;
   logic                     m_ready;

   modport master (output m_valid, output m_data, output m_last, input m_ready);
   modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/dp_ram_stream_reader_out_fifo.sv
// Two-entry output FIFO (reader_out_fifo) holding RAM words and their last flags.
module reader_out_fifo
   import dp_ram_stream_reader_pkg::*;
#(
   parameter int DATA_BITWIDTH = 512
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [DATA_BITWIDTH-1:0] push_data,
   input  logic                     push_last,
   input  logic                     pop,
   output logic [DATA_BITWIDTH-1:0] head_data,
   output logic                     head_last,
   output logic                     full,
   output logic                     empty
);
   localparam int PTR_W = $clog2(OUT_FIFO_DEPTH);
   localparam int CNT_W = $clog2(OUT_FIFO_DEPTH + 1);

   logic [DATA_BITWIDTH-1:0]  mem_data [OUT_FIFO_DEPTH];
   logic [OUT_FIFO_DEPTH-1:0] mem_last;
   logic [PTR_W-1:0]          wr_ptr;
   logic [PTR_W-1:0]          rd_ptr;
   logic [CNT_W-1:0]          count;

   // NOTE: storage is reset too, so m_data reads as zero straight out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < OUT_FIFO_DEPTH; i++) mem_data[i] <= '0;
         mem_last <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         if (push) begin
            mem_data[wr_ptr] <= push_data;
            mem_last[wr_ptr] <= push_last;
            wr_ptr           <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign head_data = mem_data[rd_ptr];
   assign head_last = mem_last[rd_ptr];
   assign full      = (count == CNT_W'(OUT_FIFO_DEPTH));
   assign empty     = (count == '0);

endmodule

// File: rtl/dp_ram_stream_reader.sv
// Reads a burst of words from a RAM read port and streams them out with backpressure.
// Optional READER_STALL_CNT_EN adds a saturating 16-bit stall_cnt output.
module dp_ram_stream_reader
   import dp_ram_stream_reader_pkg::*;
#(
   parameter int DATA_BITWIDTH = 512,
   parameter int ADDR_BITWIDTH = 5,
   parameter int DEPTH         = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [ADDR_BITWIDTH-1:0] base_addr,
   input  logic [ADDR_BITWIDTH:0]   num_words,
   output logic                     busy,
   output logic                     done,
   output logic                     ram_enb,
   output logic [ADDR_BITWIDTH-1:0] ram_addrb,
   input  logic [DATA_BITWIDTH-1:0] ram_dob,
   dp_ram_stream_reader_if.master   m
`ifdef READER_STALL_CNT_EN
   ,
   output logic [15:0]              stall_cnt
`endif
);
   ram_fsm_state_e           state, state_n;
   logic                     enb_n, last_q, last_n, done_n;
   logic [ADDR_BITWIDTH-1:0] addr_n;
   logic [ADDR_BITWIDTH:0]   rem_q, rem_n;
   logic                     fifo_full, fifo_empty, head_last, pop, can_issue;
   logic [DATA_BITWIDTH-1:0] head_data;
   logic [1:0]               occ;

   assign pop = !fifo_empty && m.m_ready;
   assign occ = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
   // The read in flight this cycle lands in the FIFO at the next edge, so it counts as occupied.
   assign can_issue = (occ + {1'b0, ram_enb} - {1'b0, pop}) < 2'd2;

   // NOTE: every variable gets a default first so no path can infer a latch.
   always_comb begin
      state_n = state;
      enb_n   = 1'b0;
      addr_n  = ram_addrb;
      rem_n   = rem_q;
      last_n  = 1'b0;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (num_words == '0) begin
                  done_n = 1'b1;
               end else begin
                  state_n = RUN;
                  enb_n   = 1'b1;
                  addr_n  = base_addr;
                  rem_n   = num_words - 1'b1;
                  last_n  = (num_words == (ADDR_BITWIDTH+1)'(1));
               end
            end
         end
         RUN: begin
            if (rem_q == '0) begin
               state_n = DRAIN;
            end else if (can_issue) begin
               enb_n  = 1'b1;
               addr_n = (ram_addrb == ADDR_BITWIDTH'(DEPTH - 1)) ? '0 : ram_addrb + 1'b1;
               rem_n  = rem_q - 1'b1;
               last_n = (rem_q == (ADDR_BITWIDTH+1)'(1));
            end
         end
         DRAIN: begin
            if (pop && head_last) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ram_enb   <= 1'b0;
         ram_addrb <= '0;
         rem_q     <= '0;
         last_q    <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         ram_enb   <= enb_n;
         ram_addrb <= addr_n;
         rem_q     <= rem_n;
         last_q    <= last_n;
         done      <= done_n;
      end
   end

   reader_out_fifo #(.DATA_BITWIDTH(DATA_BITWIDTH)) u_out_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (ram_enb),
      .push_data (ram_dob),
      .push_last (last_q),
      .pop       (pop),
      .head_data (head_data),
      .head_last (head_last),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign busy      = (state != IDLE);
   assign m.m_valid = !fifo_empty;
   assign m.m_data  = head_data;
   assign m.m_last  = head_last && !fifo_empty;

`ifdef READER_STALL_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (state == IDLE && start) begin
         stall_cnt <= '0;
      end else if (!fifo_empty && !m.m_ready && stall_cnt != 16'hFFFF) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule
